// File: rtl/sobel_ctrl_pkg.sv
// Sobel control shared definitions.
// Mode encodings, debounce states and threshold defaults.
package sobel_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_GREY     = 2'd0,
    MODE_EDGE     = 2'd1,
    MODE_EDGE_INV = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    DEB_RELEASED     = 2'd0,
    DEB_PRESS_WAIT   = 2'd1,
    DEB_PRESSED      = 2'd2,
    DEB_RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int DEB_CYCLES_DEF  = 1000000;
  localparam int THR_DEFAULT_DEF = 120;
  localparam int THR_STEP_DEF    = 8;
  localparam int THR_MIN_DEF     = 16;
  localparam int THR_MAX_DEF     = 240;

  // Mode key cycles grey -> edge -> inverted edge -> grey.
  function automatic mode_e mode_next(
    input mode_e m
  );
    mode_e r;
    unique case (m)
      MODE_GREY:     r = MODE_EDGE;
      MODE_EDGE:     r = MODE_EDGE_INV;
      MODE_EDGE_INV: r = MODE_GREY;
      default:       r = MODE_GREY;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser and debouncer.
// Emits a single-cycle pulse per accepted press.
module key_debounce
  import sobel_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  deb_state_e    r_state;
  logic [CW-1:0] r_cnt;
  deb_state_e    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_lo;
  logic          w_last;

  assign w_lo   = ~r_sync2;
  assign w_last = (r_cnt == CNT_LAST);

  // Two-flop synchroniser; idles at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // State and stability counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DEB_RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Level must hold for the full window; any bounce
  // drops back with the counter cleared.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      DEB_RELEASED: begin
        if (w_lo) begin
          w_state_nxt = DEB_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      DEB_PRESS_WAIT: begin
        if (!w_lo) begin
          w_state_nxt = DEB_RELEASED;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = DEB_PRESSED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DEB_PRESSED: begin
        if (!w_lo) begin
          w_state_nxt = DEB_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      DEB_RELEASE_WAIT: begin
        if (w_lo) begin
          w_state_nxt = DEB_PRESSED;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = DEB_RELEASED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = DEB_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pulse only on the press-accept transition.
  always_comb begin
    o_press = (r_state == DEB_PRESS_WAIT)
            & w_lo & w_last;
  end

endmodule

// File: rtl/sobel_ctrl.sv
// Sobel threshold / mode controller.
// Keys edit a working config applied at frame start.
module sobel_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int THR_DEFAULT = THR_DEFAULT_DEF,
  parameter int THR_STEP    = THR_STEP_DEF,
  parameter int THR_MIN     = THR_MIN_DEF,
  parameter int THR_MAX     = THR_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_up_n,
  input  logic        key_dn_n,
  input  logic        key_mode_n,
  input  logic        vsync_in,
  output logic [7:0]  thr_out,
  output logic [1:0]  mode_out,
  output logic        cfg_pending,
  output logic [15:0] frame_cnt
);

  localparam logic [7:0] L_DEF  = 8'(THR_DEFAULT);
  localparam logic [8:0] L_STEP = 9'(THR_STEP);
  localparam logic [8:0] L_MIN  = 9'(THR_MIN);
  localparam logic [8:0] L_MAX  = 9'(THR_MAX);

  logic        w_up;
  logic        w_dn;
  logic        w_md;
  logic        w_vs_rise;
  logic [8:0]  w_thr_sum;
  logic [7:0]  w_thr_inc;
  logic [7:0]  w_thr_dec;
  logic [7:0]  w_thr_nxt;
  mode_e       w_mode_nxt;

  logic [7:0]  r_thr;
  mode_e       r_mode;
  logic [7:0]  r_thr_out;
  mode_e       r_mode_out;
  logic        r_vs_prev;
  logic        r_pending;
  logic [15:0] r_frame_cnt;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_up_n),
    .o_press (w_up)
  );

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_dn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_dn_n),
    .o_press (w_dn)
  );

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_mode_n),
    .o_press (w_md)
  );

  assign w_vs_rise = vsync_in & ~r_vs_prev;

  // Saturating step, 9-bit sum so nothing wraps.
  always_comb begin
    w_thr_sum = {1'b0, r_thr} + L_STEP;
    w_thr_inc = (w_thr_sum > L_MAX)
              ? L_MAX[7:0] : w_thr_sum[7:0];
    w_thr_dec = ({1'b0, r_thr} < (L_MIN + L_STEP))
              ? L_MIN[7:0] : (r_thr - L_STEP[7:0]);
  end

  // Opposing presses in one cycle cancel out.
  always_comb begin
    w_thr_nxt = r_thr;
    unique case (1'b1)
      (w_up & ~w_dn): w_thr_nxt = w_thr_inc;
      (w_dn & ~w_up): w_thr_nxt = w_thr_dec;
      default:        w_thr_nxt = r_thr;
    endcase
  end

  // Mode advances independently of threshold keys.
  always_comb begin
    w_mode_nxt = w_md ? mode_next(r_mode) : r_mode;
  end

  // Working configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr  <= L_DEF;
      r_mode <= MODE_EDGE;
    end else begin
      r_thr  <= w_thr_nxt;
      r_mode <= w_mode_nxt;
    end
  end

  // Frame-start apply uses the pre-update working value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev   <= 1'b0;
      r_thr_out   <= L_DEF;
      r_mode_out  <= MODE_EDGE;
      r_frame_cnt <= '0;
    end else begin
      r_vs_prev <= vsync_in;
      if (w_vs_rise) begin
        r_thr_out   <= r_thr;
        r_mode_out  <= r_mode;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Pending flag lags the compare by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= (r_thr != r_thr_out)
                 | (r_mode != r_mode_out);
    end
  end

  assign thr_out     = r_thr_out;
  assign mode_out    = r_mode_out;
  assign cfg_pending = r_pending;
  assign frame_cnt   = r_frame_cnt;

endmodule
